// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-pipeline readout blocks.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int DEF_NUM_CH = 10;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WIN_W  = 8;

  // Generic-width saturating increment; callers zero-extend and truncate.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Host-side bundle of the spike rate decoder: window control, spike inputs and result handshake.
interface spike_rate_decoder_if #(
  parameter int NUM_CH = 10,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic                    start;
  logic [WIN_W-1:0]        window_len;
  logic                    step;
  logic [NUM_CH-1:0]       spk_in;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_CH*CNT_W-1:0] counts;
  logic [IDX_W-1:0]        winner;
  logic                    no_spike;

  modport master (
    output start, window_len, step, spk_in, out_ready,
    input  busy, out_valid, counts, winner, no_spike
  );

  modport slave (
    input  start, window_len, step, spk_in, out_ready,
    output busy, out_valid, counts, winner, no_spike
  );

endinterface

// File: rtl/spike_counter_sat.sv
// Single per-channel spike counter: synchronous clear, enable-gated saturating increment.
module spike_counter_sat
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a window of timesteps, then scans for the winning channel
// and offers counts/winner on a valid/ready handshake.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  spike_rate_decoder_if.slave bus
);

  localparam int              IDX_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] steps_left_q, steps_left_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_val_q, best_val_d;
  logic             any_q, any_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             no_spike_q, no_spike_d;

  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] cur_val;
  logic             start_ok, step_ok, last_step, scan_last, take;

  assign start_ok  = (state_q == IDLE) && bus.start;
  assign step_ok   = (state_q == COUNT) && bus.step;
  assign last_step = step_ok && (steps_left_q == WIN_W'(1));
  assign scan_last = (state_q == ARGMAX) && (idx_q == LAST_IDX);
  assign cur_val   = cnt[idx_q];
  // The first scanned channel always seeds the running best; strict > keeps ties on the lowest index.
  assign take      = (idx_q == '0) || (cur_val > best_val_q);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    spike_counter_sat #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (start_ok),
      .en_i  (step_ok & bus.spk_in[gi]),
      .cnt_o (cnt[gi])
    );
    assign bus.counts[gi*CNT_W +: CNT_W] = cnt[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.window_len == '0) ? ARGMAX : COUNT;
      COUNT:   if (last_step) state_d = ARGMAX;
      ARGMAX:  if (idx_q == LAST_IDX) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == HOLD);
    bus.winner    = winner_q;
    bus.no_spike  = no_spike_q;
  end

  always_comb begin
    steps_left_d = steps_left_q;
    idx_d        = '0;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    any_d        = any_q;
    winner_d     = winner_q;
    no_spike_d   = no_spike_q;

    if (start_ok) begin
      steps_left_d = bus.window_len;
    end else if (step_ok) begin
      steps_left_d = steps_left_q - WIN_W'(1);
    end

    if (state_q == ARGMAX) begin
      idx_d = scan_last ? '0 : idx_q + IDX_W'(1);
      if (take) begin
        best_idx_d = idx_q;
        best_val_d = cur_val;
      end
      any_d = ((idx_q == '0) ? 1'b0 : any_q) | (cur_val != '0);
      if (scan_last) begin
        winner_d   = take ? idx_q : best_idx_q;
        no_spike_d = ~(any_q | (cur_val != '0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_left_q <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      any_q        <= 1'b0;
      winner_q     <= '0;
      no_spike_q   <= 1'b0;
    end else begin
      steps_left_q <= steps_left_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
      any_q        <= any_d;
      winner_q     <= winner_d;
      no_spike_q   <= no_spike_d;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed scoreboard bench for spike_rate_decoder with 4 channels of 4-bit counters.
module tb_spike_rate_decoder;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 8;

  typedef struct packed {
    logic [15:0] counts;
    logic [1:0]  winner;
    logic        no_spike;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;
  int   n_rx;

  spike_rate_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  spike_rate_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void push_exp(input logic [15:0] c, input logic [1:0] w, input logic ns);
    exp_t e;
    e.counts   = c;
    e.winner   = w;
    e.no_spike = ns;
    exp_q.push_back(e);
  endfunction

  // Monitor: whenever a transfer is about to happen, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got counts=%h winner=%0d with no result pending", bus.counts, bus.winner);
        end else begin
          e = exp_q.pop_front();
          n_rx++;
          $display("result %0d: counts=%h winner=%0d no_spike=%0b (want %h/%0d/%0b)",
                   n_rx, bus.counts, bus.winner, bus.no_spike, e.counts, e.winner, e.no_spike);
          check("res_counts", 32'(bus.counts), 32'(e.counts));
          check("res_winner", 32'(bus.winner), 32'(e.winner));
          check("res_no_spike", 32'(bus.no_spike), 32'(e.no_spike));
        end
      end
    end
  end

  task automatic do_start(input int len);
    bus.start      = 1'b1;
    bus.window_len = WIN_W'(len);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_step(input logic s, input logic [3:0] spk);
    bus.step   = s;
    bus.spk_in = spk;
    @(negedge clk);
    bus.step   = 1'b0;
    bus.spk_in = '0;
  endtask

  // Called at the negedge right after the edge that sampled the final step (or a zero-length start).
  // The step cycle plus NUM_CH scan cycles means out_valid shows NUM_CH edges later.
  task automatic wait_valid(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        k = i;
        break;
      end
    end
    check(name, 32'(k), 32'(NUM_CH));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_rx = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.window_len = '0; bus.step = 1'b0; bus.spk_in = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_counts", 32'(bus.counts), 0);
    check("rst_winner", 32'(bus.winner), 0);
    check("rst_no_spike", 32'(bus.no_spike), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic count: ch0 every step, ch2 on steps 1 and 3.
    bus.out_ready = 1'b1;
    push_exp(16'h0205, 2'd0, 1'b0);
    do_start(5);
    check("basic_busy", 32'(bus.busy), 1);
    do_step(1'b1, 4'b0101);
    do_step(1'b1, 4'b0001);
    do_step(1'b1, 4'b0101);
    do_step(1'b1, 4'b0001);
    do_step(1'b1, 4'b0001);
    wait_valid("basic_latency");
    @(negedge clk);
    check("basic_idle_valid", 32'(bus.out_valid), 0);

    // Tie on ch1/ch3, ungated spikes and a start during COUNT must be ignored.
    push_exp(16'h3030, 2'd1, 1'b0);
    do_start(4);
    do_step(1'b1, 4'b1010);
    do_step(1'b0, 4'b1111);
    bus.start = 1'b1; bus.window_len = 8'd1;
    do_step(1'b1, 4'b1010);
    bus.start = 1'b0;
    do_step(1'b0, 4'b1111);
    do_step(1'b1, 4'b0000);
    do_step(1'b0, 4'b1111);
    do_step(1'b1, 4'b1010);
    wait_valid("tie_latency");
    @(negedge clk);

    // Saturation: ch2 spikes 20 times into a 4-bit counter, ch1 three times.
    push_exp(16'h0F30, 2'd2, 1'b0);
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      do_step(1'b1, (i < 3) ? 4'b0110 : 4'b0100);
    end
    wait_valid("sat_latency");
    @(negedge clk);

    // Zero-length window goes straight to the scan.
    push_exp(16'h0000, 2'd0, 1'b1);
    do_start(0);
    wait_valid("zero_win_latency");
    @(negedge clk);

    // Three silent steps give the same empty result.
    push_exp(16'h0000, 2'd0, 1'b1);
    do_start(3);
    do_step(1'b1, 4'b0000);
    do_step(1'b0, 4'b1111);
    do_step(1'b1, 4'b0000);
    do_step(1'b1, 4'b0000);
    wait_valid("silent_latency");
    @(negedge clk);

    // Backpressure: hold the result for 7 cycles, then a start on the transfer cycle.
    bus.out_ready = 1'b0;
    push_exp(16'h0020, 2'd1, 1'b0);
    do_start(2);
    do_step(1'b1, 4'b0010);
    do_step(1'b1, 4'b0010);
    wait_valid("bp_latency");
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.out_valid), 1);
      check("bp_hold_counts", 32'(bus.counts), 32'h0020);
      check("bp_hold_winner", 32'(bus.winner), 1);
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b1; bus.window_len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("bp_after_valid", 32'(bus.out_valid), 0);
    check("bp_after_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check("bp_start_ignored_busy", 32'(bus.busy), 0);
    check("bp_idle_winner_held", 32'(bus.winner), 1);

    // Reset mid-window after 2 of 5 steps, then a fresh window.
    do_start(5);
    do_step(1'b1, 4'b1111);
    do_step(1'b1, 4'b1111);
    bus.step = 1'b1; bus.spk_in = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_counts", 32'(bus.counts), 0);
    @(negedge clk);
    bus.step = 1'b0; bus.spk_in = '0;
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(16'h0002, 2'd0, 1'b0);
    do_start(2);
    do_step(1'b1, 4'b0001);
    do_step(1'b1, 4'b0001);
    wait_valid("postrst_latency");

    repeat (5) @(negedge clk);
    check("results_received", 32'(n_rx), 7);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
